// File: rtl/mux_pkg.sv
// Shared symbol-mux definitions: K-codes, control_dk classes, RX FSM states.
// Used by both the TX symbol mux and the RX demux.
package mux_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  localparam logic [3:0] CD_DATA = 4'd0;
  localparam logic [3:0] CD_COM  = 4'd1;
  localparam logic [3:0] CD_SKP  = 4'd2;
  localparam logic [3:0] CD_STP  = 4'd3;
  localparam logic [3:0] CD_SDP  = 4'd4;
  localparam logic [3:0] CD_END  = 4'd5;
  localparam logic [3:0] CD_EDB  = 4'd6;
  localparam logic [3:0] CD_FTS  = 4'd7;
  localparam logic [3:0] CD_IDL  = 4'd8;
  localparam logic [3:0] CD_UNK  = 4'd15;

  localparam int MAX_LEN_DEF = 64;
  localparam int OS_LEN_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT,
    ST_OS
  } rx_state_t;

  function automatic logic is_os_sym(input logic [3:0] cd);
    return (cd == CD_SKP) || (cd == CD_FTS) || (cd == CD_IDL);
  endfunction

endpackage

// File: rtl/demux_rx_if.sv
// Byte stream in / framed payload out bundle for demux_rx.
// err_cnt exists only when RX_ERR_CNT_EN is defined.
interface demux_rx_if;
  logic       enb;
  logic [7:0] rx_DataE;
  logic       rx_Valid;
  logic [7:0] rx_DataS;
  logic       data_valid;
  logic [3:0] control_dk;
  logic       pkt_start;
  logic       pkt_type;
  logic       pkt_end;
  logic       pkt_bad;
  logic [6:0] pkt_len;
  logic       os_skp;
  logic       os_fts;
  logic       os_idl;
  logic       frm_err;
`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  modport master (
    output enb, rx_DataE, rx_Valid,
`ifdef RX_ERR_CNT_EN
    input  err_cnt,
`endif
    input  rx_DataS, data_valid, control_dk,
    input  pkt_start, pkt_type, pkt_end, pkt_bad, pkt_len,
    input  os_skp, os_fts, os_idl, frm_err
  );

  modport slave (
    input  enb, rx_DataE, rx_Valid,
`ifdef RX_ERR_CNT_EN
    output err_cnt,
`endif
    output rx_DataS, data_valid, control_dk,
    output pkt_start, pkt_type, pkt_end, pkt_bad, pkt_len,
    output os_skp, os_fts, os_idl, frm_err
  );
endinterface

// File: rtl/rx_kdecode.sv
// Combinational classifier: received byte + data flag -> control_dk class.
// Data bytes are class 0 whatever their value; unlisted K bytes are 15.
import mux_pkg::*;

module rx_kdecode (
  input  logic [7:0] data,
  input  logic       valid,
  output logic [3:0] cls
);

  // map K-code byte to its class
  always_comb begin
    cls = CD_UNK;
    if (valid) begin
      cls = CD_DATA;
    end else begin
      case (data)
        K_COM:   cls = CD_COM;
        K_SKP:   cls = CD_SKP;
        K_STP:   cls = CD_STP;
        K_SDP:   cls = CD_SDP;
        K_END:   cls = CD_END;
        K_EDB:   cls = CD_EDB;
        K_FTS:   cls = CD_FTS;
        K_IDL:   cls = CD_IDL;
        default: cls = CD_UNK;
      endcase
    end
  end

endmodule

// File: rtl/demux_rx.sv
// RX symbol demux: packet framing and ordered-set tracking, 1-cycle latency.
// Define RX_ERR_CNT_EN to add the saturating framing-error counter err_cnt.
import mux_pkg::*;

module demux_rx #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int OS_LEN  = OS_LEN_DEF
) (
  input logic      clk,
  input logic      rst,
  demux_rx_if.slave bus
);

  logic [3:0] cls;
  rx_state_t  st;
  rx_state_t  eff_st;
  logic [6:0] len;
  logic [3:0] os_cnt;
  logic [3:0] os_kind;
  logic [3:0] os_sel;
  logic [3:0] os_nxt;
  logic       is_pkt;
  logic       is_com;
  logic       os_match;
  logic       os_mis;
  logic       os_done;

  rx_kdecode u_kdec (
    .data  (bus.rx_DataE),
    .valid (bus.rx_Valid),
    .cls   (cls)
  );

  // a broken ordered set falls back to IDLE handling of the same byte
  always_comb begin
    is_pkt   = (cls == CD_STP) || (cls == CD_SDP);
    is_com   = (cls == CD_COM);
    os_sel   = (os_cnt == 4'd0) ? cls : os_kind;
    os_match = (os_cnt == 4'd0) ? is_os_sym(cls)
                                : (cls == os_kind);
    os_mis   = (st == ST_OS) && !is_com && !os_match;
    os_nxt   = os_cnt + 4'd1;
    os_done  = (os_nxt == OS_LEN[3:0]);
    eff_st   = os_mis ? ST_IDLE : st;
  end

  // framing FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st             <= ST_IDLE;
      len            <= '0;
      os_cnt         <= '0;
      os_kind        <= CD_DATA;
      bus.rx_DataS   <= '0;
      bus.data_valid <= 1'b0;
      bus.control_dk <= CD_DATA;
      bus.pkt_start  <= 1'b0;
      bus.pkt_type   <= 1'b0;
      bus.pkt_end    <= 1'b0;
      bus.pkt_bad    <= 1'b0;
      bus.pkt_len    <= '0;
      bus.os_skp     <= 1'b0;
      bus.os_fts     <= 1'b0;
      bus.os_idl     <= 1'b0;
      bus.frm_err    <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.pkt_start  <= 1'b0;
      bus.pkt_end    <= 1'b0;
      bus.pkt_bad    <= 1'b0;
      bus.os_skp     <= 1'b0;
      bus.os_fts     <= 1'b0;
      bus.os_idl     <= 1'b0;
      bus.frm_err    <= 1'b0;
      if (bus.enb) begin
        bus.control_dk <= cls;
        unique case (eff_st)
          ST_IDLE: begin
            unique case (1'b1)
              is_pkt: begin
                st            <= ST_PKT;
                bus.pkt_start <= 1'b1;
                bus.pkt_type  <= (cls == CD_SDP);
                len           <= '0;
              end
              is_com: begin
                st     <= ST_OS;
                os_cnt <= '0;
              end
              default: begin
                st          <= ST_IDLE;
                bus.frm_err <= 1'b1;
              end
            endcase
          end
          ST_PKT: begin
            unique case (1'b1)
              (cls == CD_DATA): begin
                if (len < MAX_LEN[6:0]) begin
                  bus.rx_DataS   <= bus.rx_DataE;
                  bus.data_valid <= 1'b1;
                  len            <= len + 7'd1;
                end else begin
                  bus.pkt_bad <= 1'b1;
                  bus.frm_err <= 1'b1;
                  st          <= ST_IDLE;
                end
              end
              (cls == CD_END): begin
                bus.pkt_end <= 1'b1;
                bus.pkt_len <= len;
                st          <= ST_IDLE;
              end
              (cls == CD_EDB): begin
                bus.pkt_bad <= 1'b1;
                st          <= ST_IDLE;
              end
              is_pkt: begin
                bus.pkt_bad   <= 1'b1;
                bus.frm_err   <= 1'b1;
                bus.pkt_start <= 1'b1;
                bus.pkt_type  <= (cls == CD_SDP);
                len           <= '0;
              end
              is_com: begin
                bus.pkt_bad <= 1'b1;
                bus.frm_err <= 1'b1;
                st          <= ST_OS;
                os_cnt      <= '0;
              end
              default: begin
                bus.pkt_bad <= 1'b1;
                bus.frm_err <= 1'b1;
                st          <= ST_IDLE;
              end
            endcase
          end
          ST_OS: begin
            if (is_com) begin
              os_cnt <= '0;
            end else if (os_done) begin
              st         <= ST_IDLE;
              os_cnt     <= '0;
              bus.os_skp <= (os_sel == CD_SKP);
              bus.os_fts <= (os_sel == CD_FTS);
              bus.os_idl <= (os_sel == CD_IDL);
            end else begin
              os_cnt <= os_nxt;
              if (os_cnt == 4'd0) os_kind <= cls;
            end
          end
          default: st <= ST_IDLE;
        endcase
        if (os_mis) bus.frm_err <= 1'b1;
      end
    end
  end

`ifdef RX_ERR_CNT_EN
  // saturating count of framing-error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.err_cnt <= '0;
    end else if (bus.frm_err && bus.err_cnt != 8'hFF) begin
      bus.err_cnt <= bus.err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_rx.sv
// Directed scoreboard bench for demux_rx.
// Driver queues expected outputs; a monitor checks them one cycle later.
import mux_pkg::*;

module tb_demux_rx;

  localparam int F_DV = 1;
  localparam int F_PS = 2;
  localparam int F_PT = 4;
  localparam int F_PE = 8;
  localparam int F_PB = 16;
  localparam int F_SK = 32;
  localparam int F_FT = 64;
  localparam int F_IL = 128;
  localparam int F_FE = 256;
  localparam int F_NC = 512;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [3:0] cd;
    logic [6:0] pl;
    int         fl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   issued;
  int   done;
  exp_t q[$];

  demux_rx_if bus ();

  demux_rx #(.MAX_LEN(64), .OS_LEN(3)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input string nm, input logic e,
                      input logic [7:0] b, input logic v,
                      input logic [3:0] cd, input int fl,
                      input logic [7:0] d, input logic [6:0] pl);
    exp_t x;
    @(posedge clk);
    #1;
    bus.enb      = e;
    bus.rx_DataE = b;
    bus.rx_Valid = v;
    x.nm = nm;
    x.d  = d;
    x.cd = cd;
    x.pl = pl;
    x.fl = fl;
    q.push_back(x);
    issued++;
  endtask

  task automatic tx(input string nm, input logic [7:0] b,
                    input logic v, input logic [3:0] cd,
                    input int fl, input logic [7:0] d,
                    input logic [6:0] pl);
    send(nm, 1'b1, b, v, cd, fl, d, pl);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    bus.enb = 1'b0;
    for (int i = 0; i < 1000 && done != issued; i++)
      @(negedge clk);
    if (done != issued) begin
      $display("FAIL drain: done=%0d want %0d", done, issued);
      errors++;
      checks++;
    end
  endtask

  task automatic chk_reset(input string nm);
    logic ok;
    ok = bus.rx_DataS == 8'h00 && bus.data_valid == 1'b0 &&
         bus.control_dk == 4'd0 && bus.pkt_start == 1'b0 &&
         bus.pkt_type == 1'b0 && bus.pkt_end == 1'b0 &&
         bus.pkt_bad == 1'b0 && bus.pkt_len == 7'd0 &&
         bus.os_skp == 1'b0 && bus.os_fts == 1'b0 &&
         bus.os_idl == 1'b0 && bus.frm_err == 1'b0;
`ifdef RX_ERR_CNT_EN
    ok = ok && bus.err_cnt == 8'd0;
`endif
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got d=%h dv=%0b cd=%0d ps=%0b pt=%0b pe=%0b pb=%0b len=%0d os=%0b%0b%0b fe=%0b, want all zero",
               nm, bus.rx_DataS, bus.data_valid, bus.control_dk,
               bus.pkt_start, bus.pkt_type, bus.pkt_end, bus.pkt_bad,
               bus.pkt_len, bus.os_skp, bus.os_fts, bus.os_idl,
               bus.frm_err);
    end
  endtask

  // monitor: inputs sampled at this edge show up by the next negedge
  initial begin
    exp_t x;
    logic ok;
    logic f_dv, f_ps, f_pt, f_pe, f_pb, f_sk, f_ft, f_il, f_fe;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        @(negedge clk);
        f_dv = (x.fl & F_DV) != 0;
        f_ps = (x.fl & F_PS) != 0;
        f_pt = (x.fl & F_PT) != 0;
        f_pe = (x.fl & F_PE) != 0;
        f_pb = (x.fl & F_PB) != 0;
        f_sk = (x.fl & F_SK) != 0;
        f_ft = (x.fl & F_FT) != 0;
        f_il = (x.fl & F_IL) != 0;
        f_fe = (x.fl & F_FE) != 0;
        ok = bus.data_valid == f_dv &&
             (!f_dv || bus.rx_DataS == x.d) &&
             ((x.fl & F_NC) != 0 || bus.control_dk == x.cd) &&
             bus.pkt_start == f_ps &&
             (!(f_ps || f_pe || f_pb) || bus.pkt_type == f_pt) &&
             bus.pkt_end == f_pe && bus.pkt_bad == f_pb &&
             (!f_pe || bus.pkt_len == x.pl) &&
             bus.os_skp == f_sk && bus.os_fts == f_ft &&
             bus.os_idl == f_il && bus.frm_err == f_fe;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got dv=%0b d=%h cd=%0d ps=%0b pt=%0b pe=%0b pb=%0b len=%0d os=%0b%0b%0b fe=%0b, want dv=%0b d=%h cd=%0d ps=%0b pt=%0b pe=%0b pb=%0b len=%0d os=%0b%0b%0b fe=%0b",
                   x.nm, bus.data_valid, bus.rx_DataS, bus.control_dk,
                   bus.pkt_start, bus.pkt_type, bus.pkt_end,
                   bus.pkt_bad, bus.pkt_len, bus.os_skp, bus.os_fts,
                   bus.os_idl, bus.frm_err, f_dv, x.d, x.cd, f_ps,
                   f_pt, f_pe, f_pb, x.pl, f_sk, f_ft, f_il, f_fe);
        end
        done++;
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    issued = 0;
    done   = 0;
    rst_n  = 1'b0;
    bus.enb      = 1'b0;
    bus.rx_DataE = 8'h00;
    bus.rx_Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // reset mid-packet
    tx("rp_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    for (int i = 0; i < 5; i++)
      tx("rp_dat", 8'hA0 + 8'(i), 1'b1, CD_DATA, F_DV,
         8'hA0 + 8'(i), 7'd0);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tx("rp_end", K_END, 1'b0, CD_END, F_FE, 8'h00, 7'd0);

    // good TLP
    tx("tlp_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    tx("tlp_d11", 8'h11, 1'b1, CD_DATA, F_DV, 8'h11, 7'd0);
    tx("tlp_d22", 8'h22, 1'b1, CD_DATA, F_DV, 8'h22, 7'd0);
    tx("tlp_d33", 8'h33, 1'b1, CD_DATA, F_DV, 8'h33, 7'd0);
    tx("tlp_end", K_END, 1'b0, CD_END, F_PE, 8'h00, 7'd3);

    // nullified DLLP
    tx("dl_sdp", K_SDP, 1'b0, CD_SDP, F_PS | F_PT, 8'h00, 7'd0);
    tx("dl_d0", 8'hC3, 1'b1, CD_DATA, F_DV, 8'hC3, 7'd0);
    tx("dl_d1", 8'h3C, 1'b1, CD_DATA, F_DV, 8'h3C, 7'd0);
    tx("dl_edb", K_EDB, 1'b0, CD_EDB, F_PB | F_PT, 8'h00, 7'd0);

    // SKP / FTS / IDL ordered sets
    tx("skp_com", K_COM, 1'b0, CD_COM, 0, 8'h00, 7'd0);
    tx("skp_1", K_SKP, 1'b0, CD_SKP, 0, 8'h00, 7'd0);
    tx("skp_2", K_SKP, 1'b0, CD_SKP, 0, 8'h00, 7'd0);
    tx("skp_3", K_SKP, 1'b0, CD_SKP, F_SK, 8'h00, 7'd0);
    tx("fts_com", K_COM, 1'b0, CD_COM, 0, 8'h00, 7'd0);
    tx("fts_1", K_FTS, 1'b0, CD_FTS, 0, 8'h00, 7'd0);
    tx("fts_2", K_FTS, 1'b0, CD_FTS, 0, 8'h00, 7'd0);
    tx("fts_3", K_FTS, 1'b0, CD_FTS, F_FT, 8'h00, 7'd0);
    tx("idl_com", K_COM, 1'b0, CD_COM, 0, 8'h00, 7'd0);
    tx("idl_1", K_IDL, 1'b0, CD_IDL, 0, 8'h00, 7'd0);
    tx("idl_com2", K_COM, 1'b0, CD_COM, 0, 8'h00, 7'd0);
    tx("idl_r1", K_IDL, 1'b0, CD_IDL, 0, 8'h00, 7'd0);
    tx("idl_r2", K_IDL, 1'b0, CD_IDL, 0, 8'h00, 7'd0);
    tx("idl_r3", K_IDL, 1'b0, CD_IDL, F_IL, 8'h00, 7'd0);

    // broken OS: STP re-evaluated as packet open
    tx("bos_com", K_COM, 1'b0, CD_COM, 0, 8'h00, 7'd0);
    tx("bos_skp", K_SKP, 1'b0, CD_SKP, 0, 8'h00, 7'd0);
    tx("bos_stp", K_STP, 1'b0, CD_STP, F_FE | F_PS, 8'h00, 7'd0);
    tx("bos_end0", K_END, 1'b0, CD_END, F_PE, 8'h00, 7'd0);

    // errors from IDLE
    tx("idle_dat", 8'h55, 1'b1, CD_DATA, F_FE, 8'h00, 7'd0);
    tx("idle_unk", 8'h00, 1'b0, CD_UNK, F_FE, 8'h00, 7'd0);

    // restart mid-packet, then COM mid-packet
    tx("rs_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    tx("rs_d", 8'h77, 1'b1, CD_DATA, F_DV, 8'h77, 7'd0);
    tx("rs_sdp", K_SDP, 1'b0, CD_SDP, F_PB | F_FE | F_PS | F_PT,
       8'h00, 7'd0);
    tx("rs_end", K_END, 1'b0, CD_END, F_PE | F_PT, 8'h00, 7'd0);
    tx("pc_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    tx("pc_com", K_COM, 1'b0, CD_COM, F_PB | F_FE, 8'h00, 7'd0);
    tx("pc_s1", K_SKP, 1'b0, CD_SKP, 0, 8'h00, 7'd0);
    tx("pc_s2", K_SKP, 1'b0, CD_SKP, 0, 8'h00, 7'd0);
    tx("pc_s3", K_SKP, 1'b0, CD_SKP, F_SK, 8'h00, 7'd0);

    // overlength packet
    tx("ol_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    for (int i = 0; i < 64; i++)
      tx("ol_dat", 8'(i), 1'b1, CD_DATA, F_DV, 8'(i), 7'd0);
    tx("ol_65", 8'h40, 1'b1, CD_DATA, F_PB | F_FE, 8'h00, 7'd0);
    tx("ol_end", K_END, 1'b0, CD_END, F_FE, 8'h00, 7'd0);

    // enable held low mid-packet
    tx("en_stp", K_STP, 1'b0, CD_STP, F_PS, 8'h00, 7'd0);
    tx("en_d1", 8'h01, 1'b1, CD_DATA, F_DV, 8'h01, 7'd0);
    tx("en_d2", 8'h02, 1'b1, CD_DATA, F_DV, 8'h02, 7'd0);
    send("en_off1", 1'b0, K_END, 1'b0, 4'd0, F_NC, 8'h00, 7'd0);
    send("en_off2", 1'b0, K_STP, 1'b0, 4'd0, F_NC, 8'h00, 7'd0);
    send("en_off3", 1'b0, 8'h99, 1'b1, 4'd0, F_NC, 8'h00, 7'd0);
    tx("en_d3", 8'h03, 1'b1, CD_DATA, F_DV, 8'h03, 7'd0);
    tx("en_end", K_END, 1'b0, CD_END, F_PE, 8'h00, 7'd3);

`ifdef RX_ERR_CNT_EN
    for (int i = 0; i < 300; i++)
      tx("ec_err", 8'h00, 1'b1, CD_DATA, F_FE, 8'h00, 7'd0);
`endif
    drain();
`ifdef RX_ERR_CNT_EN
    checks++;
    if (bus.err_cnt != 8'hFF) begin
      errors++;
      $display("FAIL err_cnt_sat: got %0d want 255", bus.err_cnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
